// File: rtl/mmio_pkg.sv
// Shared register-select codes and status-byte layout for the MMIO responder.
`default_nettype none

package mmio_pkg;

  localparam logic [2:0] SEL_DATA = 3'd0;
  localparam logic [2:0] SEL_STAT = 3'd1;
  localparam logic [2:0] SEL_HALT = 3'd4;
  localparam logic [2:0] SEL_CNT0 = 3'd4;
  localparam logic [2:0] SEL_CNT1 = 3'd5;
  localparam logic [2:0] SEL_CNT2 = 3'd6;
  localparam logic [2:0] SEL_CNT3 = 3'd7;

  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_RX_OVF      = 6;
  localparam int STAT_TX_OVF      = 7;

  typedef struct packed {
    logic       tx_ovf;
    logic       rx_ovf;
    logic [3:0] rsvd;
    logic       rx_nonempty;
    logic       tx_full;
  } stat_t;

  function automatic logic [7:0] pack_stat(input logic tx_ovf, input logic rx_ovf,
                                           input logic rx_nonempty, input logic tx_full);
    stat_t s;
    s = '{tx_ovf: tx_ovf, rx_ovf: rx_ovf, rsvd: 4'b0,
          rx_nonempty: rx_nonempty, tx_full: tx_full};
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when it pops the same cycle.
`default_nettype none

module mmio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_responder.sv
// CPU byte-bus responder for the I/O window: TX/RX byte FIFOs, status, halt register.
// Optional MMIO_CYCLE_CNT_EN adds a 32-bit cycle counter readable at sel 4..7.
`default_nettype none

module mmio_responder
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  input  logic       en_in,
  input  logic       wr_in,
  input  logic [2:0] sel_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       full_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       halt_out,
  output logic [7:0] halt_code
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic             acc, wr_acc, rd_acc;
  logic             tx_push_req, tx_pop, tx_full, tx_empty, tx_drop;
  logic             rx_pop, rx_full, rx_empty, rx_drop;
  logic [TX_CW-1:0] tx_count, tx_free;
  logic [RX_CW-1:0] rx_count;
  logic [7:0]       rx_head;

  logic [7:0] d_out_q, d_out_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       halt_q, halt_d;
  logic [7:0] halt_code_q, halt_code_d;

  assign acc    = en_in & rdy_in;
  assign wr_acc = acc & wr_in;
  assign rd_acc = acc & ~wr_in;

  assign tx_push_req = wr_acc & (sel_in == SEL_DATA);
  assign tx_pop      = tx_ready & ~tx_empty;
  assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
  assign rx_pop      = rd_acc & (sel_in == SEL_DATA) & ~rx_empty;
  assign rx_drop     = rx_valid & rx_full & ~rx_pop;

  mmio_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .push(tx_push_req), .pop(tx_pop), .din(d_in),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_data)
  );

  mmio_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .push(rx_valid), .pop(rx_pop), .din(rx_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );

  assign tx_free   = TX_CW'(TX_DEPTH) - tx_count;
  assign full_out  = (tx_free <= TX_CW'(FULL_MARGIN));
  assign tx_valid  = ~tx_empty;
  assign d_out     = d_out_q;
  assign halt_out  = halt_q;
  assign halt_code = halt_code_q;

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [23:0] snap_q, snap_d;

  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    snap_d = snap_q;
    if (rd_acc && sel_in == SEL_CNT0) snap_d = cnt_q[31:8];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end
`endif

  always_comb begin
    d_out_d     = d_out_q;
    halt_d      = wr_acc & (sel_in == SEL_HALT);
    halt_code_d = halt_d ? d_in : halt_code_q;
    tx_ovf_d    = tx_ovf_q;
    rx_ovf_d    = rx_ovf_q;
    if (rd_acc) begin
      case (sel_in)
        SEL_DATA: d_out_d = rx_empty ? 8'h00 : rx_head;
        SEL_STAT: d_out_d = pack_stat(tx_ovf_q, rx_ovf_q, rx_count != '0, tx_full);
`ifdef MMIO_CYCLE_CNT_EN
        SEL_CNT0: d_out_d = cnt_q[7:0];
        SEL_CNT1: d_out_d = snap_q[7:0];
        SEL_CNT2: d_out_d = snap_q[15:8];
        SEL_CNT3: d_out_d = snap_q[23:16];
`endif
        default:  d_out_d = 8'h00;
      endcase
      if (sel_in == SEL_STAT) begin
        tx_ovf_d = 1'b0;
        rx_ovf_d = 1'b0;
      end
    end
    // A fresh overflow beats the read-to-clear in the same cycle.
    if (tx_drop) tx_ovf_d = 1'b1;
    if (rx_drop) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      d_out_q     <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      d_out_q     <= d_out_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

endmodule

`default_nettype wire
